control_sequencer: RTL and testbench

//  Moore FSM sequencing the 32-bit bus datapath: fetch, decode of IR[31:27], execute step by step.

---
 rtl/cpu_ctrl_pkg.sv | 67 ++++++
 rtl/ctrl_opcode_class.sv | 36 +++
 rtl/control_sequencer.sv | 173 +++++++++++++++++
 tb/tb_control_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the control sequencer.
//   Opcode values (IR[31:27]), ALU function codes, FSM phase encodings,
//   opcode-class codes, the control-strobe bundle and small decode helpers.
//   Optional feature macro: CTRL_MULDIV_EN (MUL/DIV execute sequence).
package cpu_ctrl_pkg;
  localparam int OPW_DEF     = 5;
  localparam int MAXSTEP_DEF = 7;
  localparam int STW         = 3;  // step counter width, holds T0..T7

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6,  OP_SHR  = 5'd7,  OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9,  OP_ROL  = 5'd10, OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15, OP_BR   = 5'd18, OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20, OP_IN   = 5'd21, OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23, OP_MFLO = 5'd24, OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3, ALU_SHR = 5'd4, ALU_SHL = 5'd5;
  localparam logic [4:0] ALU_ROR = 5'd6, ALU_ROL = 5'd7, ALU_MUL = 5'd8;
  localparam logic [4:0] ALU_DIV = 5'd9;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU_R, CL_ALU_I, CL_LD, CL_LDI, CL_ST, CL_BR, CL_JR,
    CL_JAL, CL_MFHI, CL_MFLO, CL_IN, CL_OUT, CL_HALT, CL_MULDIV
  } op_class_e;

  // S_RST is the quiet cycle after reset: every strobe low before FETCH0.
  typedef enum logic [2:0] {S_RST, S_F0, S_F1, S_F2, S_EXEC, S_HALT} state_e;

  typedef struct packed {
    logic gra, grb, grc, r_in, r_out, ba_out;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in;
    logic y_in, z_in, zhi_out, zlo_out, hi_in, lo_in, hi_out, lo_out;
    logic c_out, con_in, read, write;
    logic [4:0] alu_op;
    logic run;
  } ctrl_t;

  // Terminal execute step of each class.
  function automatic logic [STW-1:0] last_step(op_class_e c);
    case (c)
      CL_ALU_R, CL_ALU_I, CL_LDI: last_step = 3'd5;
      CL_LD, CL_ST:               last_step = 3'd7;
      CL_BR, CL_MULDIV:           last_step = 3'd6;
      CL_JAL:                     last_step = 3'd4;
      default:                    last_step = 3'd3;
    endcase
  endfunction

  function automatic logic [4:0] alu_sel(logic [4:0] op);
    case (op)
      OP_SUB:          alu_sel = ALU_SUB;
      OP_AND, OP_ANDI: alu_sel = ALU_AND;
      OP_OR, OP_ORI:   alu_sel = ALU_OR;
      OP_SHR:          alu_sel = ALU_SHR;
      OP_SHL:          alu_sel = ALU_SHL;
      OP_ROR:          alu_sel = ALU_ROR;
      OP_ROL:          alu_sel = ALU_ROL;
      OP_MUL:          alu_sel = ALU_MUL;
      OP_DIV:          alu_sel = ALU_DIV;
      default:         alu_sel = ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_opcode_class.sv
// ctrl_opcode_class: combinational opcode -> execute-class decode.
//   opcode in  OPW  IR[31:27]
//   cls    out      op_class_e; unknown opcodes map to CL_NOP
//   CTRL_MULDIV_EN: when defined MUL/DIV decode to CL_MULDIV, else CL_NOP.
module ctrl_opcode_class
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic [OPW-1:0] opcode,
  output op_class_e      cls
);
  always_comb begin
    cls = CL_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CL_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:       cls = CL_ALU_I;
      OP_LD:                          cls = CL_LD;
      OP_LDI:                         cls = CL_LDI;
      OP_ST:                          cls = CL_ST;
      OP_BR:                          cls = CL_BR;
      OP_JR:                          cls = CL_JR;
      OP_JAL:                         cls = CL_JAL;
      OP_IN:                          cls = CL_IN;
      OP_OUT:                         cls = CL_OUT;
      OP_MFHI:                        cls = CL_MFHI;
      OP_MFLO:                        cls = CL_MFLO;
      OP_HALT:                        cls = CL_HALT;
`ifdef CTRL_MULDIV_EN
      OP_MUL, OP_DIV:                 cls = CL_MULDIV;
`endif
      default:                        cls = CL_NOP;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM driving the 32-bit bus datapath.
//   Inputs : clk, reset (sync, active-high), ir[31:0], con_ff, mem_done, stop
//   Outputs: register strobes (gra/grb/grc/r_in/r_out/ba_out), bus and memory
//            strobes, Y/Z/HI/LO strobes, read/write, alu_op[4:0], run.
//   Fetch FETCH0..2, then execute T3..MAXSTEP by opcode class.
//   CTRL_MULDIV_EN: enables the MUL/DIV execute sequence.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW     = OPW_DEF,
  parameter int MAXSTEP = MAXSTEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_done,
  input  logic        stop,
  output logic gra, grb, grc, r_in, r_out, ba_out,
  output logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
  output logic y_in, z_in, zhi_out, zlo_out, hi_in, lo_in, hi_out, lo_out,
  output logic c_out, con_in,
  output logic read, write,
  output logic [4:0] alu_op,
  output logic run
);
  localparam logic [STW-1:0] STEP_MAX = STW'(MAXSTEP);

  state_e         state_q, state_d;
  logic [STW-1:0] step_q, step_d;
  op_class_e      cls_q, cls_d, dec_cls;
  logic [OPW-1:0] op_q, op_d;
  logic           take_q, take_d;   // branch decision captured at end of T5
  logic           mem_wait, boundary;
  ctrl_t          c;
  logic           unused_ir;

  assign unused_ir = ^ir[31-OPW:0];

  ctrl_opcode_class #(.OPW(OPW)) u_dec (.opcode(ir[31:32-OPW]), .cls(dec_cls));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      step_q  <= '0;
      cls_q   <= CL_NOP;
      op_q    <= '0;
      take_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cls_q   <= cls_d;
      op_q    <= op_d;
      take_q  <= take_d;
    end
  end

  // Execute steps that stall on memory completion.
  assign mem_wait = (cls_q == CL_LD && step_q == 3'd6) ||
                    (cls_q == CL_ST && step_q == 3'd7);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cls_d    = cls_q;
    op_d     = op_q;
    take_d   = take_q;
    boundary = 1'b0;
    case (state_q)
      S_RST: boundary = 1'b1;
      S_F0:  state_d  = S_F1;
      S_F1:  if (mem_done) state_d = S_F2;
      S_F2: begin
        state_d = S_EXEC;
        step_d  = 3'd3;
        cls_d   = dec_cls;
        op_d    = ir[31:32-OPW];
      end
      S_EXEC: begin
        if (cls_q == CL_BR && step_q == 3'd5) take_d = con_ff;
        if (mem_wait && !mem_done) state_d = S_EXEC;
        else if (cls_q == CL_HALT) state_d = S_HALT;
        else if (step_q >= last_step(cls_q) || step_q == STEP_MAX) boundary = 1'b1;
        else step_d = STW'(step_q + 3'd1);
      end
      default: state_d = state_q;  // S_HALT: only reset leaves
    endcase
    // stop is looked at only when entering FETCH0.
    if (boundary) state_d = stop ? S_HALT : S_F0;
  end

  always_comb begin
    c        = '0;
    c.alu_op = ALU_ADD;
    c.run    = 1'b1;
    case (state_q)
      S_F0:   begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
      S_F1:   begin c.zlo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
      S_F2:   begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_HALT: c.run = 1'b0;
      S_EXEC: begin
        case (cls_q)
          CL_ALU_R, CL_ALU_I: case (step_q)
            3'd3: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
            3'd4: begin
              c.z_in = 1'b1; c.alu_op = alu_sel(op_q);
              if (cls_q == CL_ALU_R) begin c.grc = 1'b1; c.r_out = 1'b1; end
              else c.c_out = 1'b1;
            end
            3'd5: begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            default: ;
          endcase
          CL_LD, CL_LDI, CL_ST: case (step_q)
            3'd3: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
            3'd4: begin c.c_out = 1'b1; c.z_in = 1'b1; end
            3'd5: begin
              c.zlo_out = 1'b1;
              if (cls_q == CL_LDI) begin c.gra = 1'b1; c.r_in = 1'b1; end
              else c.mar_in = 1'b1;
            end
            3'd6: begin
              c.mdr_in = 1'b1;
              if (cls_q == CL_ST) begin c.gra = 1'b1; c.r_out = 1'b1; end
              else c.read = 1'b1;
            end
            3'd7: begin
              if (cls_q == CL_ST) c.write = 1'b1;
              else begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            end
            default: ;
          endcase
          CL_BR: case (step_q)
            3'd3: begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
            3'd4: begin c.pc_out = 1'b1; c.y_in = 1'b1; end
            3'd5: begin c.c_out = 1'b1; c.z_in = 1'b1; end
            3'd6: begin c.zlo_out = take_q; c.pc_in = take_q; end
            default: ;
          endcase
          CL_JR:   if (step_q == 3'd3) begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
          CL_JAL: case (step_q)
            3'd3: begin c.pc_out = 1'b1; c.grb = 1'b1; c.r_in = 1'b1; end
            3'd4: begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
            default: ;
          endcase
          CL_MFHI: if (step_q == 3'd3) begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          CL_MFLO: if (step_q == 3'd3) begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          CL_IN:   if (step_q == 3'd3) begin c.gra = 1'b1; c.r_in = 1'b1; end
          CL_OUT:  if (step_q == 3'd3) begin c.gra = 1'b1; c.r_out = 1'b1; end
`ifdef CTRL_MULDIV_EN
          CL_MULDIV: case (step_q)
            3'd3: begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
            3'd4: begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_op = alu_sel(op_q); end
            3'd5: begin c.zlo_out = 1'b1; c.lo_in = 1'b1; end
            3'd6: begin c.zhi_out = 1'b1; c.hi_in = 1'b1; end
            default: ;
          endcase
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign {gra, grb, grc, r_in, r_out, ba_out} = {c.gra, c.grb, c.grc, c.r_in, c.r_out, c.ba_out};
  assign {pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in} =
         {c.pc_out, c.pc_in, c.inc_pc, c.mar_in, c.mdr_in, c.mdr_out, c.ir_in};
  assign {y_in, z_in, zhi_out, zlo_out, hi_in, lo_in, hi_out, lo_out} =
         {c.y_in, c.z_in, c.zhi_out, c.zlo_out, c.hi_in, c.lo_in, c.hi_out, c.lo_out};
  assign {c_out, con_in, read, write} = {c.c_out, c.con_in, c.read, c.write};
  assign alu_op = c.alu_op;
  assign run    = c.run;
endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer. Each test pushes the expected strobe word
// for every cycle (plus the inputs to drive in that cycle) onto a scoreboard
// queue, then drains it, comparing the DUT strobes at each falling edge.
// Honours CTRL_MULDIV_EN for the MUL expectations.
module tb_control_sequencer;
  logic clk, reset, con_ff, mem_done, stop;
  logic [31:0] ir;
  logic gra, grb, grc, r_in, r_out, ba_out, pc_out, pc_in, inc_pc, mar_in;
  logic mdr_in, mdr_out, ir_in, y_in, z_in, zhi_out, zlo_out, hi_in, lo_in;
  logic hi_out, lo_out, c_out, con_in, read, write, run;
  logic [4:0] alu_op;

  control_sequencer dut (
    .clk(clk), .reset(reset), .ir(ir), .con_ff(con_ff), .mem_done(mem_done), .stop(stop),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .zhi_out(zhi_out),
    .zlo_out(zlo_out), .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
    .c_out(c_out), .con_in(con_in), .read(read), .write(write), .alu_op(alu_op), .run(run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed strobe word: one bit per strobe, alu_op in [29:25], run in [30].
  logic [31:0] obs;
  assign obs = {1'b0, run, alu_op, write, read, con_in, c_out, lo_out, hi_out, lo_in, hi_in,
                zlo_out, zhi_out, z_in, y_in, ir_in, mdr_out, mdr_in, mar_in, inc_pc,
                pc_in, pc_out, ba_out, r_out, r_in, grc, grb, gra};

  localparam logic [31:0] GRA = 32'd1 << 0,  GRB = 32'd1 << 1,  GRC = 32'd1 << 2;
  localparam logic [31:0] RIN = 32'd1 << 3,  ROUT = 32'd1 << 4, BAOUT = 32'd1 << 5;
  localparam logic [31:0] PCOUT = 32'd1 << 6, PCIN = 32'd1 << 7, INCPC = 32'd1 << 8;
  localparam logic [31:0] MARIN = 32'd1 << 9, MDRIN = 32'd1 << 10, MDROUT = 32'd1 << 11;
  localparam logic [31:0] IRIN = 32'd1 << 12, YIN = 32'd1 << 13, ZIN = 32'd1 << 14;
  localparam logic [31:0] ZHIOUT = 32'd1 << 15, ZLOOUT = 32'd1 << 16, HIIN = 32'd1 << 17;
  localparam logic [31:0] LOIN = 32'd1 << 18, HIOUT = 32'd1 << 19, LOOUT = 32'd1 << 20;
  localparam logic [31:0] COUT = 32'd1 << 21, CONIN = 32'd1 << 22, READ = 32'd1 << 23;
  localparam logic [31:0] WRITE = 32'd1 << 24, RUN = 32'd1 << 30;
  localparam logic [31:0] A_SUB = 32'd1 << 25, A_MUL = 32'd8 << 25;
  localparam logic [31:0] W_F0 = RUN | PCOUT | MARIN | INCPC | ZIN;
  localparam logic [31:0] W_F1 = RUN | ZLOOUT | PCIN | READ | MDRIN;
  localparam logic [31:0] W_F2 = RUN | MDROUT | IRIN;

  typedef struct {
    logic [31:0] w;
    bit md, stp, rst;
    string nm;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0;
  exp_t e;
  logic [31:0] o;

  function automatic void push(logic [31:0] w, bit md, bit stp, bit rst, string nm);
    exp_t x;
    x.w = w; x.md = md; x.stp = stp; x.rst = rst; x.nm = nm;
    exp_q.push_back(x);
  endfunction

  function automatic void push_fetch();
    push(W_F0, 1, 0, 0, "F0"); push(W_F1, 1, 0, 0, "F1"); push(W_F2, 1, 0, 0, "F2");
  endfunction

  // Observe the current state, then drive this cycle's inputs.
  task automatic next_cycle(output exp_t ex, output logic [31:0] ob);
    @(negedge clk);
    ob = obs;
    ex = exp_q.pop_front();
    mem_done = ex.md; stop = ex.stp; reset = ex.rst;
  endtask

  task automatic test_reset();
    push(RUN, 1, 0, 1, "rst_hold"); push(RUN, 1, 0, 0, "rst_rel");
    while (exp_q.size() > 0) begin
      next_cycle(e, o); n_chk++;
      if (o !== e.w) $display("FAIL reset %s: got %h want %h", e.nm, o, e.w); else n_pass++;
    end
  endtask

  task automatic test_alu_r();
    ir = {OP3(), 4'd3, 4'd1, 4'd2, 15'd0};
    push_fetch();
    push(RUN | GRB | ROUT | YIN, 1, 0, 0, "add_T3");
    push(RUN | GRC | ROUT | ZIN, 1, 0, 0, "add_T4");
    push(RUN | ZLOOUT | GRA | RIN, 1, 0, 0, "add_T5");
    while (exp_q.size() > 0) begin
      next_cycle(e, o); n_chk++;
      if (o !== e.w) $display("FAIL alu_add %s: got %h want %h", e.nm, o, e.w); else n_pass++;
    end
    ir = {5'd4, 4'd5, 4'd6, 4'd7, 15'd0};
    push_fetch();
    push(RUN | GRB | ROUT | YIN, 1, 0, 0, "sub_T3");
    push(RUN | GRC | ROUT | ZIN | A_SUB, 1, 0, 0, "sub_T4");
    push(RUN | ZLOOUT | GRA | RIN, 1, 0, 0, "sub_T5");
    while (exp_q.size() > 0) begin
      next_cycle(e, o); n_chk++;
      if (o !== e.w) $display("FAIL alu_sub %s: got %h want %h", e.nm, o, e.w); else n_pass++;
    end
  endtask

  function automatic logic [4:0] OP3();
    return 5'd3;
  endfunction

  task automatic test_ld_wait();
    // 8 base cycles + 2 waits in FETCH1 + 1 wait in T6 = 11 cycles
    ir = {5'd0, 4'd1, 4'd2, 19'h10};
    push(W_F0, 0, 0, 0, "F0");
    push(W_F1, 0, 0, 0, "F1_w1"); push(W_F1, 0, 0, 0, "F1_w2"); push(W_F1, 1, 0, 0, "F1_go");
    push(W_F2, 1, 0, 0, "F2");
    push(RUN | GRB | BAOUT | YIN, 1, 0, 0, "ld_T3");
    push(RUN | COUT | ZIN, 1, 0, 0, "ld_T4");
    push(RUN | ZLOOUT | MARIN, 1, 0, 0, "ld_T5");
    push(RUN | READ | MDRIN, 0, 0, 0, "ld_T6_w");
    push(RUN | READ | MDRIN, 1, 0, 0, "ld_T6_go");
    push(RUN | MDROUT | GRA | RIN, 1, 0, 0, "ld_T7");
    while (exp_q.size() > 0) begin
      next_cycle(e, o); n_chk++;
      if (o !== e.w) $display("FAIL ld_wait %s: got %h want %h", e.nm, o, e.w); else n_pass++;
    end
  endtask

  task automatic test_branch(input bit cf);
    ir = {5'd18, 4'd2, 4'd0, 19'h8};
    con_ff = cf;
    push_fetch();
    push(RUN | GRA | ROUT | CONIN, 1, 0, 0, "br_T3");
    push(RUN | PCOUT | YIN, 1, 0, 0, "br_T4");
    push(RUN | COUT | ZIN, 1, 0, 0, "br_T5");
    push(cf ? (RUN | ZLOOUT | PCIN) : RUN, 1, 0, 0, "br_T6");
    while (exp_q.size() > 0) begin
      next_cycle(e, o); n_chk++;
      if (o !== e.w) $display("FAIL branch_con%0d %s: got %h want %h", cf, e.nm, o, e.w);
      else n_pass++;
    end
    con_ff = 1'b0;
  endtask

  task automatic test_reset_mid_ld();
    ir = {5'd0, 4'd1, 4'd2, 19'h10};
    push_fetch();
    push(RUN | GRB | BAOUT | YIN, 1, 0, 0, "ld_T3");
    push(RUN | COUT | ZIN, 1, 0, 1, "ld_T4");
    push(RUN, 1, 0, 1, "rst_c1");
    push(RUN, 1, 0, 0, "rst_c2");
    while (exp_q.size() > 0) begin
      next_cycle(e, o); n_chk++;
      if (o !== e.w) $display("FAIL reset_mid_ld %s: got %h want %h", e.nm, o, e.w); else n_pass++;
    end
  endtask

  task automatic test_illegal();
    ir = {5'd31, 27'h0};
    push_fetch();
    push(RUN, 1, 0, 0, "ill_T3");
    while (exp_q.size() > 0) begin
      next_cycle(e, o); n_chk++;
      if (o !== e.w) $display("FAIL illegal %s: got %h want %h", e.nm, o, e.w); else n_pass++;
    end
  endtask

  task automatic test_muldiv();
    ir = {5'd14, 4'd0, 4'd3, 4'd4, 15'd0};
    push_fetch();
`ifdef CTRL_MULDIV_EN
    push(RUN | GRA | ROUT | YIN, 1, 0, 0, "mul_T3");
    push(RUN | GRB | ROUT | ZIN | A_MUL, 1, 0, 0, "mul_T4");
    push(RUN | ZLOOUT | LOIN, 1, 0, 0, "mul_T5");
    push(RUN | ZHIOUT | HIIN, 1, 0, 0, "mul_T6");
`else
    push(RUN, 1, 0, 0, "mul_nop_T3");
`endif
    while (exp_q.size() > 0) begin
      next_cycle(e, o); n_chk++;
      if (o !== e.w) $display("FAIL muldiv %s: got %h want %h", e.nm, o, e.w); else n_pass++;
    end
  endtask

  task automatic test_halt_op();
    ir = {5'd26, 27'h0};
    push_fetch();
    push(RUN, 1, 0, 0, "halt_T3");
    push(32'd0, 1, 0, 0, "halted1");
    push(32'd0, 1, 0, 1, "halted2");
    push(RUN, 1, 0, 0, "rst_idle");
    while (exp_q.size() > 0) begin
      next_cycle(e, o); n_chk++;
      if (o !== e.w) $display("FAIL halt_op %s: got %h want %h", e.nm, o, e.w); else n_pass++;
    end
  endtask

  task automatic test_stop();
    ir = {5'd3, 4'd3, 4'd1, 4'd2, 15'd0};
    push_fetch();
    push(RUN | GRB | ROUT | YIN, 1, 1, 0, "stop_T3");
    push(RUN | GRC | ROUT | ZIN, 1, 1, 0, "stop_T4");
    push(RUN | ZLOOUT | GRA | RIN, 1, 1, 0, "stop_T5");
    push(32'd0, 1, 0, 0, "halt1");
    push(32'd0, 1, 0, 0, "halt2");
    push(32'd0, 1, 0, 1, "halt3");
    push(RUN, 1, 0, 0, "rst_idle");
    push(W_F0, 1, 0, 0, "F0_after");
    while (exp_q.size() > 0) begin
      next_cycle(e, o); n_chk++;
      if (o !== e.w) $display("FAIL stop %s: got %h want %h", e.nm, o, e.w); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; ir = '0; con_ff = 1'b0; mem_done = 1'b1; stop = 1'b0;
    @(posedge clk);
    test_reset();
    test_alu_r();
    test_ld_wait();
    test_branch(1'b0);
    test_branch(1'b1);
    test_reset_mid_ld();
    test_illegal();
    test_muldiv();
    test_halt_op();
    test_stop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1);
  end
endmodule
